fifo_prog_sync: RTL and testbench
=================================

Name: fifo_prog_sync

Overview:
- Next-generation single-clock synchronous FIFO for the verification environment's DUT family.
- Generalises the current 16x8 FIFO in four ways:
  - any depth, including non-power-of-two;
  - programmable almost-full and almost-empty thresholds;
  - selectable standard-read or first-word-fall-through (FWFT) read mode;
  - sticky overflow/underflow error status with software clear.
- Keeps the existing handshake and flag semantics so existing sequences and assertions carry over.

Parameters:
- FIFO_WIDTH, 16: data width in bits, >=1.
- FIFO_DEPTH, 8: number of entries, >=2, need not be a power of two.
- AF_LEVEL, FIFO_DEPTH-1: almostfull threshold, 1..FIFO_DEPTH-1.
- AE_LEVEL, 1: almostempty threshold, 1..FIFO_DEPTH-1.
- FWFT, 0: read mode. 0 = standard (registered read); 1 = first-word-fall-through.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- data_in  in  FIFO_WIDTH  write data.
- wr_en  in  1  write request.
- rd_en  in  1  read request.
- clr_err  in  1  clears the sticky error bits.
- data_out  out  FIFO_WIDTH  read data.
- wr_ack  out  1  previous-cycle write accepted.
- overflow  out  1  previous-cycle write rejected.
- underflow  out  1  previous-cycle read rejected.
- ovf_sticky  out  1  latched overflow.
- udf_sticky  out  1  latched underflow.
- full  out  1  count == FIFO_DEPTH.
- empty  out  1  count == 0.
- almostfull  out  1  AF_LEVEL <= count < FIFO_DEPTH.
- almostempty  out  1  0 < count <= AE_LEVEL.
- count  out  $clog2(FIFO_DEPTH+1)  current occupancy.

Behaviour:
- Reset (asynchronous, active-low):
  - wr_ptr, rd_ptr, count = 0.
  - data_out, wr_ack, overflow, underflow, ovf_sticky, udf_sticky = 0.
  - empty = 1; full, almostfull, almostempty = 0.
  - Storage array is not reset.
- Pointer width: max($clog2(FIFO_DEPTH),1). Each pointer advances by 1 and wraps explicitly from FIFO_DEPTH-1 to 0; no modulo on width.
- Write accept: wr_en && (!full || (rd_en && FWFT==1 && full)). Without that FWFT case, accept is wr_en && !full.
  - On accept: mem[wr_ptr] <= data_in, wr_ptr advances, wr_ack <= 1 on the next cycle.
  - wr_en while full and not accepted: overflow <= 1 on the next cycle.
  - wr_ack and overflow are cleared every cycle in which their condition is absent (single-cycle pulses).
- Read accept: rd_en && !empty.
  - Standard mode: data_out <= mem[rd_ptr] (one-cycle latency); data_out holds its value otherwise.
  - FWFT mode: data_out = mem[rd_ptr] whenever !empty (zero latency); rd_en pops the entry and rd_ptr advances. While empty, data_out = 0.
  - rd_en while empty: underflow <= 1 on the next cycle, pulsed the same way.
- Simultaneous wr_en && rd_en:
  - Empty: write only; count +1; no underflow flagged in this case.
  - Full, standard mode: read only; count -1; overflow pulses.
  - Full, FWFT mode: read and write both accepted; count unchanged; no overflow.
  - Otherwise: both accepted; count unchanged.
- Count: +1 on write-only accept, -1 on read-only accept, unchanged otherwise. Never exceeds FIFO_DEPTH or drops below 0.
- Flags: full, empty, almostfull, almostempty are combinational from the registered count (same cycle as count).
- Sticky bits:
  - ovf_sticky / udf_sticky set on the cycle their pulse is set.
  - clr_err clears them on the next edge.
  - If clr_err coincides with a new error, the set wins.
- Reset mid-operation: all state returns to reset values immediately; in-flight pulses are dropped.
- Elaboration check: error if AF_LEVEL or AE_LEVEL is outside 1..FIFO_DEPTH-1, or FIFO_DEPTH < 2.

Decomposition:
- fifo_pkg:
  - read-mode enum (STD_READ, FWFT_READ);
  - functions for pointer width and count width;
  - default-width constants shared with the UVM environment and the assertion module.
- Sub-module fifo_mem_sdp:
  - simple dual-port array, FIFO_WIDTH x FIFO_DEPTH;
  - synchronous write, asynchronous read;
  - the top registers the read data in standard mode.
- Top contains the pointers, count, handshake and flag logic.

Test Plan:
- DEPTH=6, standard mode: write 6 words 0x0001..0x0006.
  - count goes 1..6; almostfull asserted at count 5 only; full at 6.
  - A 7th write gives overflow=1 the next cycle and ovf_sticky=1.
- DEPTH=6, standard mode, continuing from full: read 6 words.
  - data_out returns 0x0001..0x0006, each one cycle after rd_en.
  - wr_ptr and rd_ptr wrap 5 -> 0.
  - A 7th read gives underflow=1 and udf_sticky=1.
- FWFT=1: write 0xABCD into the empty FIFO.
  - The cycle after the write, data_out=0xABCD with rd_en low.
  - rd_en pops it; empty=1 the next cycle.
- FWFT=1, full, wr_en=rd_en=1.
  - count stays at FIFO_DEPTH; wr_ack=1; overflow=0.
- Standard mode, empty, wr_en=rd_en=1 with data 0x1234.
  - count=1; wr_ack=1; underflow=0.
  - With AE_LEVEL=2: almostempty=1.
- rst_n low mid-burst with count=3: all outputs at reset values immediately.
- Sticky clear: clr_err pulsed together with a new overflow → ovf_sticky stays 1. clr_err alone the next cycle → ovf_sticky = 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types, default widths and sizing helpers for the programmable FIFO family.
package fifo_pkg;

  typedef enum logic {
    STD_READ  = 1'b0,
    FWFT_READ = 1'b1
  } read_mode_e;

  localparam int DEFAULT_FIFO_WIDTH = 16;
  localparam int DEFAULT_FIFO_DEPTH = 8;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_mem_sdp.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset on the array.
module fifo_mem_sdp #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int PW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_prog_sync.sv
// Single-clock FIFO with arbitrary depth, programmable thresholds, STD/FWFT read
// and sticky error status. Pointers, occupancy, handshakes and flags live here.
module fifo_prog_sync
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = DEFAULT_FIFO_WIDTH,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int AE_LEVEL   = 1,
  parameter int FWFT       = 0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [FIFO_WIDTH-1:0]             data_in,
  input  logic                              wr_en,
  input  logic                              rd_en,
  input  logic                              clr_err,
  output logic [FIFO_WIDTH-1:0]             data_out,
  output logic                              wr_ack,
  output logic                              overflow,
  output logic                              underflow,
  output logic                              ovf_sticky,
  output logic                              udf_sticky,
  output logic                              full,
  output logic                              empty,
  output logic                              almostfull,
  output logic                              almostempty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count
);

  localparam int         PW   = ptr_width(FIFO_DEPTH);
  localparam int         CW   = count_width(FIFO_DEPTH);
  localparam read_mode_e MODE = (FWFT != 0) ? FWFT_READ : STD_READ;

  if (FIFO_DEPTH < 2 || AF_LEVEL < 1 || AF_LEVEL > FIFO_DEPTH - 1 ||
      AE_LEVEL < 1 || AE_LEVEL > FIFO_DEPTH - 1) begin : g_param_check
    $error("fifo_prog_sync: illegal FIFO_DEPTH/AF_LEVEL/AE_LEVEL");
  end

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [FIFO_WIDTH-1:0] rd_data;
  logic [FIFO_WIDTH-1:0] data_q;
  logic                  wr_accept;
  logic                  rd_accept;
  logic                  ovf_set;
  logic                  udf_set;

  // Depth need not be a power of two, so wrap explicitly instead of relying on overflow.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // In FWFT mode a full FIFO can take a write in the same cycle the head is popped.
  assign wr_accept = wr_en && (!full || (rd_en && MODE == FWFT_READ));
  assign rd_accept = rd_en && !empty;
  assign ovf_set   = wr_en && !wr_accept;
  assign udf_set   = rd_en && empty && !wr_en;

  fifo_mem_sdp #(
    .WIDTH(FIFO_WIDTH),
    .DEPTH(FIFO_DEPTH),
    .PW   (PW)
  ) u_mem (
    .clk  (clk),
    .we   (wr_accept),
    .waddr(wr_ptr),
    .wdata(data_in),
    .raddr(rd_ptr),
    .rdata(rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_q     <= '0;
      wr_ack     <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      ovf_sticky <= 1'b0;
      udf_sticky <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= next_ptr(wr_ptr);
      if (rd_accept) rd_ptr <= next_ptr(rd_ptr);
      if (wr_accept && !rd_accept)      count <= count + CW'(1);
      else if (rd_accept && !wr_accept) count <= count - CW'(1);
      if (rd_accept && MODE == STD_READ) data_q <= rd_data;
      wr_ack    <= wr_accept;
      overflow  <= ovf_set;
      underflow <= udf_set;
      // A new error beats a simultaneous clear.
      if (ovf_set)      ovf_sticky <= 1'b1;
      else if (clr_err) ovf_sticky <= 1'b0;
      if (udf_set)      udf_sticky <= 1'b1;
      else if (clr_err) udf_sticky <= 1'b0;
    end
  end

  assign full        = (count == CW'(FIFO_DEPTH));
  assign empty       = (count == '0);
  assign almostfull  = (count >= CW'(AF_LEVEL)) && !full;
  assign almostempty = !empty && (count <= CW'(AE_LEVEL));
  assign data_out    = (MODE == FWFT_READ) ? (empty ? '0 : rd_data) : data_q;

endmodule

// File: tb/tb_fifo_prog_sync.sv
// Drives a standard-read and an FWFT instance with identical stimulus and compares
// both against queue-based reference models.
module tb_fifo_prog_sync;

  localparam int W  = 16;
  localparam int D  = 6;
  localparam int AF = 5;
  localparam int AE = 2;
  localparam int CW = $clog2(D + 1);

  typedef logic [W-1:0] word_q_t [$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_en = 1'b0;
  logic rd_en = 1'b0;
  logic clr_err = 1'b0;
  logic [W-1:0] data_in = '0;

  logic [1:0][W-1:0]  dout;
  logic [1:0][CW-1:0] cnt;
  logic [1:0] ack, ovf, udf, os, us, fl, em, af, ae;

  int checks = 0;
  int errors = 0;

  word_q_t q_std;
  word_q_t q_fw;
  logic [W-1:0] e_dq [2];
  logic e_ack [2];
  logic e_ovf [2];
  logic e_udf [2];
  logic e_os  [2];
  logic e_us  [2];

  always #5 clk = ~clk;

  fifo_prog_sync #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en), .clr_err(clr_err),
    .data_out(dout[0]), .wr_ack(ack[0]), .overflow(ovf[0]), .underflow(udf[0]),
    .ovf_sticky(os[0]), .udf_sticky(us[0]), .full(fl[0]), .empty(em[0]),
    .almostfull(af[0]), .almostempty(ae[0]), .count(cnt[0])
  );

  fifo_prog_sync #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en), .clr_err(clr_err),
    .data_out(dout[1]), .wr_ack(ack[1]), .overflow(ovf[1]), .underflow(udf[1]),
    .ovf_sticky(os[1]), .udf_sticky(us[1]), .full(fl[1]), .empty(em[1]),
    .almostfull(af[1]), .almostempty(ae[1]), .count(cnt[1])
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock of the reference FIFO: pop happens before push so a full FWFT FIFO can swap.
  task automatic modelStep(input bit fw, input bit wr, input bit rd, input logic [W-1:0] din,
                           input bit clr, inout word_q_t q, inout logic [W-1:0] dq,
                           output logic a, output logic o, output logic u,
                           inout logic so, inout logic su);
    bit emp;
    bit ful;
    bit wacc;
    bit racc;
    emp  = (q.size() == 0);
    ful  = (q.size() == D);
    wacc = wr && (!ful || (fw && rd));
    racc = rd && !emp;
    if (racc) begin
      if (!fw) dq = q[0];
      void'(q.pop_front());
    end
    if (wacc) q.push_back(din);
    a  = wacc;
    o  = wr && !wacc;
    u  = rd && emp && !wr;
    so = o ? 1'b1 : (clr ? 1'b0 : so);
    su = u ? 1'b1 : (clr ? 1'b0 : su);
  endtask

  task automatic checkMode(input int m, input word_q_t q);
    int n;
    string p;
    logic [W-1:0] ed;
    n  = q.size();
    p  = (m == 0) ? "std." : "fwft.";
    ed = (m == 1) ? ((n > 0) ? q[0] : '0) : e_dq[m];
    checkOutput({p, "data_out"},    32'(dout[m]), 32'(ed));
    checkOutput({p, "count"},       32'(cnt[m]),  32'(n));
    checkOutput({p, "full"},        32'(fl[m]),   32'(n == D));
    checkOutput({p, "empty"},       32'(em[m]),   32'(n == 0));
    checkOutput({p, "almostfull"},  32'(af[m]),   32'(n >= AF && n < D));
    checkOutput({p, "almostempty"}, 32'(ae[m]),   32'(n > 0 && n <= AE));
    checkOutput({p, "wr_ack"},      32'(ack[m]),  32'(e_ack[m]));
    checkOutput({p, "overflow"},    32'(ovf[m]),  32'(e_ovf[m]));
    checkOutput({p, "underflow"},   32'(udf[m]),  32'(e_udf[m]));
    checkOutput({p, "ovf_sticky"},  32'(os[m]),   32'(e_os[m]));
    checkOutput({p, "udf_sticky"},  32'(us[m]),   32'(e_us[m]));
  endtask

  task automatic applyStimulus(input bit wr, input bit rd, input logic [W-1:0] din, input bit clr);
    wr_en   = wr;
    rd_en   = rd;
    data_in = din;
    clr_err = clr;
    @(posedge clk);
    modelStep(1'b0, wr, rd, din, clr, q_std, e_dq[0], e_ack[0], e_ovf[0], e_udf[0], e_os[0], e_us[0]);
    modelStep(1'b1, wr, rd, din, clr, q_fw,  e_dq[1], e_ack[1], e_ovf[1], e_udf[1], e_os[1], e_us[1]);
    @(negedge clk);
    checkMode(0, q_std);
    checkMode(1, q_fw);
  endtask

  // Called away from the rising edge; outputs must clear without waiting for a clock.
  task automatic doReset();
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    clr_err = 1'b0;
    rst_n   = 1'b0;
    #1;
    q_std.delete();
    q_fw.delete();
    for (int m = 0; m < 2; m++) begin
      e_dq[m] = '0; e_ack[m] = 1'b0; e_ovf[m] = 1'b0;
      e_udf[m] = 1'b0; e_os[m] = 1'b0; e_us[m] = 1'b0;
    end
    checkMode(0, q_std);
    checkMode(1, q_fw);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2;
    doReset();

    for (int i = 1; i <= 7; i++) applyStimulus(1'b1, 1'b0, W'(i), 1'b0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, '0, 1'b0);

    applyStimulus(1'b1, 1'b1, 16'h1234, 1'b0);
    applyStimulus(1'b0, 1'b1, '0, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'hABCD, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b1, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);

    for (int i = 0; i < D; i++) applyStimulus(1'b1, 1'b0, W'(16'h0100 + i), 1'b0);
    applyStimulus(1'b1, 1'b1, 16'h0BEE, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h0077, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h0078, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);

    for (int i = 0; i < D; i++) applyStimulus(1'b0, 1'b1, '0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, W'(16'h0200 + i), 1'b0);
    doReset();

    for (int i = 0; i < 600; i++) begin
      int pw;
      pw = ((i / 60) % 2 == 0) ? 75 : 25;
      applyStimulus($urandom_range(99) < pw, $urandom_range(99) < (100 - pw),
                    W'($urandom), $urandom_range(99) < 8);
      if (i == 300) doReset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
